rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port (A3/WD3/WE3) between NUM_REQ writeback
//  sources (ALU result, load data, ...). Round-robin arbitration, valid/ready per
//  requester, registered output, one write per cycle. Sits between the writeback
//  sources and register_file; optionally diverts R15 writes to the PC.
// PARAMETERS
//  NUM_REQ  2   number of writeback requesters (2..4)
//  ADDR_W   4   register address width
//  DATA_W   32  write data width
// PORTS
//  clk          in   1                clock, rising edge
//  rst          in   1                reset, asynchronous, active-high
//  req_valid    in   NUM_REQ          requester i has a write pending
//  req_ready    out  NUM_REQ          requester i's write accepted this cycle (one-hot or 0)
//  req_addr     in   NUM_REQ*ADDR_W   destination register, requester i at [i*ADDR_W +: ADDR_W]
//  req_data     in   NUM_REQ*DATA_W   write data, requester i at [i*DATA_W +: DATA_W]
//  rf_stall     in   1                suspend all grants this cycle
//  rf_we        out  1                to register_file WE3
//  rf_addr      out  ADDR_W           to register_file A3
//  rf_data      out  DATA_W           to register_file WD3
//  grant_id     out  $clog2(NUM_REQ)  index of requester driving the current rf_* beat
//  err_r15      out  1                sticky: an R15 write was dropped (macro absent)
//  pc_load      out  1                PC redirect strobe (RF_PC_REDIRECT_EN only)
//  pc_data      out  DATA_W           PC redirect value (RF_PC_REDIRECT_EN only)
// BEHAVIOUR
//  - Reset: rf_we=0, rf_addr=0, rf_data=0, grant_id=0, err_r15=0, pc_load=0, pc_data=0,
//    RR pointer=0 (requester 0 has highest priority).
//  - req_ready combinational from req_valid, pointer, rf_stall. At most one bit set.
//    rf_stall=1 -> req_ready=0.
//  - Transfer on req_valid[i] && req_ready[i]. The requester holds addr/data stable
//    while valid && !ready. Once valid is asserted, it is never withdrawn before transfer.
//  - Priority search starts at pointer and wraps modulo NUM_REQ. After a grant to i,
//    pointer <= (i+1) mod NUM_REQ. No grant -> pointer holds.
//  - Latency: transfer in cycle N -> rf_we=1 with rf_addr/rf_data/grant_id in cycle N+1.
//    No transfer in N -> rf_we=0 in N+1. rf_addr/rf_data hold their last values.
//  - Throughput: one write per cycle. Back-to-back grants are allowed. Worst-case wait
//    is NUM_REQ-1 cycles for a continuously valid requester, with no stall.
//  - rst asserted mid-operation: the in-flight beat is lost, outputs and pointer clear
//    immediately, and no grant is issued while rst=1.
//  - Address 15 (PC): never presented on rf_we. It is handled by the configuration below.
// CONFIGURATION
//  RF_PC_REDIRECT_EN defined:
//    - A transfer with addr=15 still gets req_ready and advances the pointer.
//    - Cycle N+1: rf_we=0, pc_load=1, pc_data=data.
//    - err_r15 is tied 0.
//  RF_PC_REDIRECT_EN undefined:
//    - An addr=15 transfer is accepted and dropped (rf_we=0).
//    - err_r15 is set in N+1 and stays set until rst.
//    - pc_load=0 and pc_data=0 permanently.
// STRUCTURE
//  - Package regfile_pkg:
//    - RF_ADDR_W=4, RF_DATA_W=32, REG_PC=4'd15.
//    - typedef struct packed {logic [RF_ADDR_W-1:0] addr; logic [RF_DATA_W-1:0] data;} rf_wr_t.
//  - Sub-module rr_arbiter #(N): req[N], pointer register, one-hot gnt[N], gnt_idx.
//    Pointer updates only on enable && |gnt.
//  - Top: rr_arbiter instance, request mux, output register stage, R15 decode and
//    redirect/error logic.
// TESTING
//  - Reset: assert rst mid-stream with req_valid=2'b11 -> same cycle rf_we=0, err_r15=0,
//    req_ready=0. After release, the first grant goes to requester 0.
//  - Single write: req0 addr=3 data=32'hDEAD_BEEF at N -> req_ready=2'b01 at N.
//    rf_we=1, rf_addr=3, rf_data=DEADBEEF, grant_id=0 at N+1, then rf_we=0 at N+2.
//  - Contention: both valid, 4 writes each -> grants alternate 0,1,0,1,...
//    8 consecutive rf_we pulses, each requester's data in order.
//  - Stall: both valid, rf_stall=1 for 3 cycles -> req_ready=0 and rf_we=0 throughout,
//    pointer unchanged. The first grant after stall matches the pre-stall pointer.
//  - R15, macro undefined: req1 addr=15 -> accepted, rf_we=0, err_r15=1 until rst.
//  - R15, macro defined: req1 addr=15 data=32'h100 -> pc_load=1, pc_data=32'h100,
//    rf_we=0 at N+1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
//   RF_ADDR_W / RF_DATA_W : default register address and data widths
//   REG_PC                : architectural register number of the program counter
//   rf_wr_t               : one register-file write beat (address + data)
package regfile_pkg;

  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset (pointer -> 0)
//   enable    : when low no grant is issued and the pointer holds
//   req[N]    : request vector
//   gnt[N]    : one-hot grant (or zero), combinational
//   gnt_idx   : binary index of the granted requester (0 when no grant)
// The search starts at the pointer and wraps; after a grant to i the pointer
// moves to i+1 so that requester gets the lowest priority next time.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    ptr_d   = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && enable && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        found    = 1'b1;
      end
    end
    if (found) begin
      ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Shares the single register-file write port between NUM_REQ writeback sources
// with round-robin arbitration and a registered output beat.
//   clk, rst        : clock, asynchronous active-high reset
//   req_valid/ready : per-requester handshake, ready is combinational and one-hot
//   req_addr/data   : packed per-requester write address / data
//   rf_stall        : suppresses all grants this cycle
//   rf_we/addr/data : registered write beat towards the register file
//   grant_id        : requester that produced the current rf_* beat
//   err_r15         : sticky flag, an R15 write was dropped
//   pc_load/pc_data : PC redirect strobe and value
// Build option: define RF_PC_REDIRECT_EN to turn R15 writes into PC redirects;
// otherwise they are dropped and flagged on err_r15.
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_addr,
  output logic [DATA_W-1:0]         rf_data,
  output logic [ID_W-1:0]           grant_id,
  output logic                      err_r15,
  output logic                      pc_load,
  output logic [DATA_W-1:0]         pc_data
);

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               arb_en;
  logic               xfer;
  logic               is_pc;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ID_W-1:0]   gid_q, gid_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Grants are also blocked while reset is held, not just once it releases.
  assign arb_en = !rf_stall && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .enable  (arb_en),
    .req     (req_valid),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_addr  = addr_arr[gnt_idx];
  assign sel_data  = data_arr[gnt_idx];
  assign is_pc     = (sel_addr == ADDR_W'(REG_PC));

  // R15 never reaches the register file; address/data/id only move on a real write.
  always_comb begin
    we_d   = xfer && !is_pc;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (we_d) begin
      addr_d = sel_addr;
      data_d = sel_data;
      gid_d  = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_addr  = addr_q;
  assign rf_data  = data_q;
  assign grant_id = gid_q;

`ifdef RF_PC_REDIRECT_EN
  logic              pcl_q, pcl_d;
  logic [DATA_W-1:0] pcd_q, pcd_d;

  always_comb begin
    pcl_d = xfer && is_pc;
    pcd_d = pcl_d ? sel_data : pcd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcl_q <= 1'b0;
      pcd_q <= '0;
    end else begin
      pcl_q <= pcl_d;
      pcd_q <= pcd_d;
    end
  end

  assign pc_load = pcl_q;
  assign pc_data = pcd_q;
  assign err_r15 = 1'b0;
`else
  logic err_q, err_d;

  always_comb begin
    err_d = err_q || (xfer && is_pc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_r15 = err_q;
  assign pc_load = 1'b0;
  assign pc_data = '0;
`endif

endmodule
